// File: rtl/cnn_layer_accel_octo_input_sched.sv
// Feature-map load scheduler for cnn_layer_accel_octo: validates geometry, drives derived cfg,
// then streams sequence words followed by pixel words over one tagged, registered datain bus.
module cnn_layer_accel_octo_input_sched #(
  parameter int C_PIXEL_WIDTH    = 16,
  parameter int C_SEQ_DATA_WIDTH = 13,
  parameter int C_DIM_WIDTH      = 10
) (
  input  logic                        clk_500MHz,
  input  logic                        rst_n,
  input  logic                        start,
  input  logic [C_DIM_WIDTH-1:0]      cfg_rows,
  input  logic [C_DIM_WIDTH-1:0]      cfg_cols,
  input  logic [C_DIM_WIDTH-1:0]      cfg_kernel,
  input  logic [C_SEQ_DATA_WIDTH-1:0] seq_in_data,
  input  logic                        seq_in_valid,
  output logic                        seq_in_rdy,
  input  logic [C_PIXEL_WIDTH-1:0]    pix_in_data,
  input  logic                        pix_in_valid,
  output logic                        pix_in_rdy,
  output logic                        new_map,
  output logic [C_DIM_WIDTH-1:0]      num_input_rows_cfg,
  output logic [C_DIM_WIDTH-1:0]      num_input_cols_cfg,
  output logic [C_DIM_WIDTH-1:0]      num_output_rows_cfg,
  output logic [C_DIM_WIDTH-1:0]      num_output_cols_cfg,
  output logic [C_DIM_WIDTH+2:0]      seq_full_count_cfg,
  output logic [C_DIM_WIDTH-1:0]      row_matric_done_count_cfg,
  output logic [C_PIXEL_WIDTH-1:0]    datain,
  output logic                        datain_valid,
  output logic                        seq_datain_tag,
  output logic                        pixel_datain_tag,
  input  logic                        seq_datain_rdy,
  input  logic                        pixel_datain_rdy,
  output logic                        busy,
  output logic                        done,
  output logic                        cfg_err
);

  localparam int SEQ_CW = C_DIM_WIDTH + 3;
  localparam int PIX_CW = 2 * C_DIM_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CFG,
    S_NEWMAP,
    S_SEQ,
    S_GAP,
    S_PIX
  } state_e;

  state_e state_q, state_d;

  logic [C_DIM_WIDTH-1:0]   rows_q, rows_d;
  logic [C_DIM_WIDTH-1:0]   in_rows_q, in_rows_d;
  logic [C_DIM_WIDTH-1:0]   in_cols_q, in_cols_d;
  logic [C_DIM_WIDTH-1:0]   out_rows_q, out_rows_d;
  logic [C_DIM_WIDTH-1:0]   out_cols_q, out_cols_d;
  logic [SEQ_CW-1:0]        seq_full_q, seq_full_d;
  logic [C_DIM_WIDTH-1:0]   cols_q, cols_d;
  logic [SEQ_CW-1:0]        seq_rem_q, seq_rem_d;
  logic [PIX_CW-1:0]        pix_rem_q, pix_rem_d;
  logic [PIX_CW-1:0]        acc_rem_q, acc_rem_d;
  logic [C_PIXEL_WIDTH-1:0] data_q, data_d;
  logic                     valid_q, valid_d;
  logic                     seq_tag_q, seq_tag_d;
  logic                     pix_tag_q, pix_tag_d;
  logic                     done_q, done_d;
  logic                     cfg_err_q, cfg_err_d;

  logic              geom_ok;
  logic              start_idle;
  logic              dn_acc;
  logic              out_free;
  logic              last_acc;
  logic              seq_fire;
  logic              pix_fire;
  logic [PIX_CW-1:0] pix_total;

  assign geom_ok    = (cfg_kernel != '0) && (cfg_kernel <= cfg_rows) && (cfg_kernel <= cfg_cols);
  assign start_idle = start && (state_q == S_IDLE);

  // The output register accepts a new word when empty or when its word leaves this cycle.
  assign dn_acc   = valid_q && ((seq_tag_q && seq_datain_rdy) || (pix_tag_q && pixel_datain_rdy));
  assign out_free = !valid_q || dn_acc;
  assign last_acc = dn_acc && (acc_rem_q == PIX_CW'(1));

  assign seq_in_rdy = (state_q == S_SEQ) && (seq_rem_q != '0) && out_free;
  assign pix_in_rdy = (state_q == S_PIX) && (pix_rem_q != '0) && out_free;
  assign seq_fire   = seq_in_valid && seq_in_rdy;
  assign pix_fire   = pix_in_valid && pix_in_rdy;

  assign pix_total = PIX_CW'(rows_q) * PIX_CW'(cols_q);

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_500MHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start && geom_ok) state_d = S_CFG;
      S_CFG:    state_d = S_NEWMAP;
      S_NEWMAP: state_d = S_SEQ;
      S_SEQ:    if (last_acc) state_d = S_GAP;
      S_GAP:    state_d = S_PIX;
      S_PIX:    if (last_acc) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    new_map = 1'b0;
    busy    = 1'b1;
    case (state_q)
      S_IDLE:   busy    = 1'b0;
      S_NEWMAP: new_map = 1'b1;
      default:  ;
    endcase
  end

  always_comb begin
    rows_d     = rows_q;
    in_rows_d  = in_rows_q;
    in_cols_d  = in_cols_q;
    out_rows_d = out_rows_q;
    out_cols_d = out_cols_q;
    seq_full_d = seq_full_q;
    cols_d     = cols_q;
    seq_rem_d  = seq_rem_q;
    pix_rem_d  = pix_rem_q;
    acc_rem_d  = acc_rem_q;
    data_d     = data_q;
    valid_d    = valid_q;
    seq_tag_d  = seq_tag_q;
    pix_tag_d  = pix_tag_q;
    done_d     = 1'b0;
    cfg_err_d  = 1'b0;

    if (start_idle) begin
      if (geom_ok) begin
        rows_d     = cfg_rows;
        cols_d     = cfg_cols;
        in_rows_d  = cfg_rows - C_DIM_WIDTH'(1);
        in_cols_d  = cfg_cols - C_DIM_WIDTH'(1);
        out_rows_d = cfg_rows - cfg_kernel;
        out_cols_d = cfg_cols - cfg_kernel;
        // Widened before subtracting so (cols-k+1)*5 cannot wrap inside the field width.
        seq_full_d = (SEQ_CW'(cfg_cols) - SEQ_CW'(cfg_kernel) + SEQ_CW'(1)) * SEQ_CW'(5);
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (seq_fire) seq_rem_d = seq_rem_q - SEQ_CW'(1);
    if (pix_fire) pix_rem_d = pix_rem_q - PIX_CW'(1);
    if (dn_acc)   acc_rem_d = acc_rem_q - PIX_CW'(1);

    case (state_q)
      S_NEWMAP: begin
        seq_rem_d = seq_full_q;
        pix_rem_d = pix_total;
        acc_rem_d = PIX_CW'(seq_full_q);
      end
      S_GAP:   acc_rem_d = pix_total;
      S_PIX:   if (last_acc) done_d = 1'b1;
      default: ;
    endcase

    if (seq_fire) begin
      data_d    = C_PIXEL_WIDTH'(seq_in_data);
      valid_d   = 1'b1;
      seq_tag_d = 1'b1;
      pix_tag_d = 1'b0;
    end else if (pix_fire) begin
      data_d    = pix_in_data;
      valid_d   = 1'b1;
      seq_tag_d = 1'b0;
      pix_tag_d = 1'b1;
    end else if (dn_acc) begin
      valid_d   = 1'b0;
      seq_tag_d = 1'b0;
      pix_tag_d = 1'b0;
    end
  end

  always_ff @(posedge clk_500MHz or negedge rst_n) begin
    if (!rst_n) begin
      rows_q     <= '0;
      in_rows_q  <= '0;
      in_cols_q  <= '0;
      out_rows_q <= '0;
      out_cols_q <= '0;
      seq_full_q <= '0;
      cols_q     <= '0;
      seq_rem_q  <= '0;
      pix_rem_q  <= '0;
      acc_rem_q  <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      seq_tag_q  <= 1'b0;
      pix_tag_q  <= 1'b0;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
    end else begin
      rows_q     <= rows_d;
      in_rows_q  <= in_rows_d;
      in_cols_q  <= in_cols_d;
      out_rows_q <= out_rows_d;
      out_cols_q <= out_cols_d;
      seq_full_q <= seq_full_d;
      cols_q     <= cols_d;
      seq_rem_q  <= seq_rem_d;
      pix_rem_q  <= pix_rem_d;
      acc_rem_q  <= acc_rem_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      seq_tag_q  <= seq_tag_d;
      pix_tag_q  <= pix_tag_d;
      done_q     <= done_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  assign num_input_rows_cfg        = in_rows_q;
  assign num_input_cols_cfg        = in_cols_q;
  assign num_output_rows_cfg       = out_rows_q;
  assign num_output_cols_cfg       = out_cols_q;
  assign seq_full_count_cfg        = seq_full_q;
  assign row_matric_done_count_cfg = cols_q;
  assign datain                    = data_q;
  assign datain_valid              = valid_q;
  assign seq_datain_tag            = seq_tag_q;
  assign pixel_datain_tag          = pix_tag_q;
  assign done                      = done_q;
  assign cfg_err                   = cfg_err_q;

endmodule

// File: tb/tb_cnn_layer_accel_octo_input_sched.sv
// Bench for cnn_layer_accel_octo_input_sched: directed map loads checked against an ordered
// word model every cycle, plus literal cfg expectations for a few fixed geometries.
module tb_cnn_layer_accel_octo_input_sched;
  localparam int PW = 16;
  localparam int SW = 13;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] cfg_rows = '0, cfg_cols = '0, cfg_kernel = '0;
  logic [SW-1:0] seq_in_data = '0;
  logic          seq_in_valid = 1'b0;
  logic          seq_in_rdy;
  logic [PW-1:0] pix_in_data = '0;
  logic          pix_in_valid = 1'b0;
  logic          pix_in_rdy;
  logic          new_map;
  logic [DW-1:0] num_input_rows_cfg, num_input_cols_cfg;
  logic [DW-1:0] num_output_rows_cfg, num_output_cols_cfg;
  logic [DW+2:0] seq_full_count_cfg;
  logic [DW-1:0] row_matric_done_count_cfg;
  logic [PW-1:0] datain;
  logic          datain_valid, seq_datain_tag, pixel_datain_tag;
  logic          seq_datain_rdy = 1'b0, pixel_datain_rdy = 1'b0;
  logic          busy, done, cfg_err;

  cnn_layer_accel_octo_input_sched #(
    .C_PIXEL_WIDTH(PW), .C_SEQ_DATA_WIDTH(SW), .C_DIM_WIDTH(DW)
  ) dut (
    .clk_500MHz(clk), .rst_n(rst_n), .start(start),
    .cfg_rows(cfg_rows), .cfg_cols(cfg_cols), .cfg_kernel(cfg_kernel),
    .seq_in_data(seq_in_data), .seq_in_valid(seq_in_valid), .seq_in_rdy(seq_in_rdy),
    .pix_in_data(pix_in_data), .pix_in_valid(pix_in_valid), .pix_in_rdy(pix_in_rdy),
    .new_map(new_map),
    .num_input_rows_cfg(num_input_rows_cfg), .num_input_cols_cfg(num_input_cols_cfg),
    .num_output_rows_cfg(num_output_rows_cfg), .num_output_cols_cfg(num_output_cols_cfg),
    .seq_full_count_cfg(seq_full_count_cfg), .row_matric_done_count_cfg(row_matric_done_count_cfg),
    .datain(datain), .datain_valid(datain_valid),
    .seq_datain_tag(seq_datain_tag), .pixel_datain_tag(pixel_datain_tag),
    .seq_datain_rdy(seq_datain_rdy), .pixel_datain_rdy(pixel_datain_rdy),
    .busy(busy), .done(done), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int exp_seq_n = 0, exp_pix_n = 0, salt = 0;
  int acc_seq = 0, acc_pix = 0, up_seq = 0, up_pix = 0;
  int newmap_total = 0, done_total = 0, cfgerr_total = 0;
  int sidx = 0, pidx = 0;
  bit seq_fire_s = 0, pix_fire_s = 0, dn_acc_s = 0;
  bit exp_done_nx = 0, exp_gap_nx = 0, prev_hold = 0;
  logic [PW-1:0] prev_data = '0;
  logic [1:0]    prev_tags = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [SW-1:0] seq_word(input int i);
    int v;
    v = i * 53 + 17 + salt * 311;
    return v[SW-1:0];
  endfunction

  function automatic logic [PW-1:0] pix_word(input int i);
    int v;
    v = i * 257 + 1000 + salt * 97;
    return v[PW-1:0];
  endfunction

  // Reference model: words must leave in source order, sequence class first, then a gap, then pixels.
  always @(negedge clk) begin
    if (!rst_n) begin
      seq_fire_s = 0; pix_fire_s = 0; dn_acc_s = 0;
      exp_done_nx = 0; exp_gap_nx = 0; prev_hold = 0;
    end else begin
      seq_fire_s = seq_in_valid && seq_in_rdy;
      pix_fire_s = pix_in_valid && pix_in_rdy;
      dn_acc_s = datain_valid && ((seq_datain_tag && seq_datain_rdy) ||
                                  (pixel_datain_tag && pixel_datain_rdy));
      if (new_map) begin
        newmap_total++;
        acc_seq = 0; acc_pix = 0; up_seq = 0; up_pix = 0;
      end
      if (cfg_err) cfgerr_total++;
      if (done) done_total++;
      check("tag_excl", seq_datain_tag & pixel_datain_tag, 0);
      check("tag_needs_valid", (seq_datain_tag | pixel_datain_tag) & ~datain_valid, 0);
      check("valid_needs_tag", datain_valid & ~(seq_datain_tag | pixel_datain_tag), 0);
      if (prev_hold) begin
        check("hold_valid", datain_valid, 1);
        check("hold_data", datain, prev_data);
        check("hold_tags", {seq_datain_tag, pixel_datain_tag}, prev_tags);
      end
      check("done_pulse", done, exp_done_nx);
      exp_done_nx = 0;
      if (exp_gap_nx) begin
        check("gap_valid", datain_valid, 0);
        check("gap_pix_rdy", pix_in_rdy, 0);
        check("gap_busy", busy, 1);
        exp_gap_nx = 0;
      end
      check("seq_rdy_bound", seq_in_rdy && (up_seq >= exp_seq_n), 0);
      check("pix_rdy_bound", pix_in_rdy && (up_pix >= exp_pix_n), 0);
      check("pix_rdy_phase", pix_in_rdy && (acc_seq < exp_seq_n), 0);
      if (seq_fire_s) up_seq++;
      if (pix_fire_s) up_pix++;
      if (dn_acc_s) begin
        if (seq_datain_tag) begin
          check("seq_word", datain, {{(PW-SW){1'b0}}, seq_word(acc_seq)});
          acc_seq++;
          if (acc_seq == exp_seq_n) exp_gap_nx = 1;
        end else begin
          check("pix_order", acc_seq, exp_seq_n);
          check("pix_word", datain, pix_word(acc_pix));
          acc_pix++;
          if (acc_pix == exp_pix_n) exp_done_nx = 1;
        end
      end
      prev_hold = datain_valid && !dn_acc_s;
      prev_data = datain;
      prev_tags = {seq_datain_tag, pixel_datain_tag};
    end
  end

  task automatic check_outputs_zero(input string tag);
    check({tag, "_cfg"}, {num_input_rows_cfg, num_input_cols_cfg, num_output_rows_cfg,
                          num_output_cols_cfg, seq_full_count_cfg, row_matric_done_count_cfg}, 0);
    check({tag, "_io"}, {datain, datain_valid, seq_datain_tag, pixel_datain_tag, busy, done,
                         cfg_err, new_map, seq_in_rdy, pix_in_rdy}, 0);
  endtask

  task automatic drive(input bit rdy_rand, input bit gap_rand);
    seq_in_data      = seq_word(sidx);
    pix_in_data      = pix_word(pidx);
    seq_in_valid     = gap_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    pix_in_valid     = gap_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    seq_datain_rdy   = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
    pixel_datain_rdy = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
  endtask

  task automatic run_load(input int r, input int c, input int k, input int seq_lit,
                          input int pix_lit, input bit rdy_rand, input bit gap_rand,
                          input bit start_noise, input int abort_at);
    int nm0, dn0, ce0;
    bit fin, aborted;
    nm0 = newmap_total; dn0 = done_total; ce0 = cfgerr_total;
    fin = 0; aborted = 0;
    salt++;
    exp_seq_n = (c - k + 1) * 5;
    exp_pix_n = r * c;
    sidx = 0; pidx = 0;
    cfg_rows = DW'(r); cfg_cols = DW'(c); cfg_kernel = DW'(k);
    drive(rdy_rand, gap_rand);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("cfg_in_rows", num_input_rows_cfg, r - 1);
    check("cfg_in_cols", num_input_cols_cfg, c - 1);
    check("cfg_out_rows", num_output_rows_cfg, r - k);
    check("cfg_out_cols", num_output_cols_cfg, c - k);
    check("cfg_seq_full", seq_full_count_cfg, exp_seq_n);
    check("cfg_seq_lit", seq_full_count_cfg, seq_lit);
    check("cfg_row_done", row_matric_done_count_cfg, c);
    check("cfg_busy", busy, 1);
    check("cfg_no_newmap", new_map, 0);
    for (int cyc = 0; cyc < 4000 && !fin && !aborted; cyc++) begin
      drive(rdy_rand, gap_rand);
      if (start_noise && acc_seq < exp_seq_n) begin
        start = $urandom_range(0, 1) != 0;
        cfg_kernel = start ? '0 : DW'(k);
      end else begin
        start = 1'b0;
        cfg_kernel = DW'(k);
      end
      @(posedge clk); #1;
      if (seq_fire_s) sidx++;
      if (pix_fire_s) pidx++;
      if (abort_at >= 0 && acc_pix == abort_at) begin
        #2 rst_n = 1'b0;
        #1 check_outputs_zero("abort");
        start = 1'b0; seq_in_valid = 1'b0; pix_in_valid = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        aborted = 1;
      end
      if (done_total != dn0) fin = 1;
    end
    start = 1'b0;
    cfg_kernel = DW'(k);
    if (aborted) begin
      check("abort_no_done", done_total - dn0, 0);
      check("abort_busy", busy, 0);
    end else begin
      check("load_finished", fin, 1);
      check("newmap_count", newmap_total - nm0, 1);
      check("done_count", done_total - dn0, 1);
      check("no_cfg_err", cfgerr_total - ce0, 0);
      check("seq_accepts", acc_seq, seq_lit);
      check("pix_accepts", acc_pix, pix_lit);
      check("seq_upstream", sidx, seq_lit);
      check("pix_upstream", pidx, pix_lit);
      check("end_busy", busy, 0);
      check("end_cfg_seq", seq_full_count_cfg, exp_seq_n);
      check("end_cfg_out_cols", num_output_cols_cfg, c - k);
    end
  endtask

  task automatic bad_start(input int r, input int c, input int k);
    int nm0, ce0;
    nm0 = newmap_total; ce0 = cfgerr_total;
    cfg_rows = DW'(r); cfg_cols = DW'(c); cfg_kernel = DW'(k);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("bad_cfg_err", cfg_err, 1);
    check("bad_busy", busy, 0);
    repeat (4) begin
      @(posedge clk); #1;
      check("bad_err_clear", cfg_err, 0);
      check("bad_idle", busy, 0);
    end
    check("bad_newmap", newmap_total - nm0, 0);
    check("bad_err_count", cfgerr_total - ce0, 1);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 check_outputs_zero("reset");
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_load(10, 10, 3, 40, 100, 0, 0, 0, -1);
    check("lit_in_rows", num_input_rows_cfg, 9);
    check("lit_in_cols", num_input_cols_cfg, 9);
    check("lit_out_rows", num_output_rows_cfg, 7);
    check("lit_out_cols", num_output_cols_cfg, 7);
    check("lit_seq_full", seq_full_count_cfg, 40);
    check("lit_row_done", row_matric_done_count_cfg, 10);

    run_load(10, 10, 3, 40, 100, 1, 0, 0, -1);
    run_load(10, 10, 3, 40, 100, 1, 1, 1, -1);

    bad_start(10, 10, 11);
    bad_start(8, 8, 0);
    bad_start(10, 4, 5);

    run_load(3, 3, 3, 5, 9, 1, 1, 0, -1);
    check("lit_k_eq_out_rows", num_output_rows_cfg, 0);
    check("lit_k_eq_out_cols", num_output_cols_cfg, 0);
    check("lit_k_eq_seq_full", seq_full_count_cfg, 5);

    run_load(1, 1, 1, 5, 1, 0, 0, 0, -1);
    run_load(6, 9, 2, 40, 54, 1, 0, 0, -1);
    check("lit_6x9_out_rows", num_output_rows_cfg, 4);
    check("lit_6x9_out_cols", num_output_cols_cfg, 7);

    run_load(10, 10, 3, 40, 100, 0, 0, 0, 37);
    run_load(10, 10, 3, 40, 100, 1, 1, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
